// File: rtl/kf8255_port_a_handshake_if.sv
// Port A bus/handshake bundle for the 8255 Group A handshake sequencer.
//   master: the CPU/pin side (drives bus, strobes and pins; sees status)
//   slave : the handshake sequencer itself
// Signals:
//   internal_data_bus  CPU write data
//   write_port_a       one-cycle pulse at the end of a port A write
//   read_port_a        level, high during a port A read
//   port_a_pin_in      asynchronous port A pins
//   stb_n / ack_n      PC4 strobe / PC6 acknowledge, asynchronous, active low
//   port_a_read_data   data returned on a port A read
//   port_a_out_data    output latch
//   port_a_out_enable  port A pin driver enable
//   obf_n / ibf / intr Group A handshake lines (PC7 / PC5 / PC3)
interface kf8255_port_a_handshake_if;
  logic [7:0] internal_data_bus;
  logic       write_port_a;
  logic       read_port_a;
  logic [7:0] port_a_pin_in;
  logic       stb_n;
  logic       ack_n;
  logic [7:0] port_a_read_data;
  logic [7:0] port_a_out_data;
  logic       port_a_out_enable;
  logic       obf_n;
  logic       ibf;
  logic       intr;

  modport master (
    output internal_data_bus, write_port_a, read_port_a, port_a_pin_in, stb_n, ack_n,
    input  port_a_read_data, port_a_out_data, port_a_out_enable, obf_n, ibf, intr
  );

  modport slave (
    input  internal_data_bus, write_port_a, read_port_a, port_a_pin_in, stb_n, ack_n,
    output port_a_read_data, port_a_out_data, port_a_out_enable, obf_n, ibf, intr
  );
endinterface

// File: rtl/kf8255_port_a_handshake.sv
// Handshake sequencer for 8255 Group A, port A, Modes 1 and 2.
// Latches strobed input data, holds output data and drives OBF_n/IBF/INTR.
// Mode 0 is transparent with all handshake outputs inactive.
// Ports:
//   clock          system clock, all state updates on its falling edge
//   reset          asynchronous, active-high
//   group_a_mode   00 Mode 0, 01 Mode 1, 1x Mode 2
//   port_a_dir_in  Modes 0/1: 1 input, 0 output
//   mode_write     mode-set pulse, same effect as reset
//   inte1 / inte2  output-side / input-side interrupt enables
//   pa             port A bus/handshake bundle (slave view)
module kf8255_port_a_handshake #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] group_a_mode,
  input  logic       port_a_dir_in,
  input  logic       mode_write,
  input  logic       inte1,
  input  logic       inte2,
  kf8255_port_a_handshake_if.slave pa
);

  typedef enum logic {IN_EMPTY, IN_FULL}   in_state_t;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  logic [SYNC_STAGES-1:0] stb_sync, ack_sync;
  logic [7:0]             pin_sync [SYNC_STAGES];
  logic                   stb_d, ack_d, read_d;
  logic                   stb_s, ack_s;
  logic [7:0]             pin_s;
  logic                   stb_fall, stb_rise, ack_fall, ack_rise, read_rise, read_fall;

  logic       intr_in, intr_out, intr_q, armed;
  logic       intr_in_next, intr_out_next, intr_next, load_latch;
  logic [7:0] in_latch, out_data;
  logic       mode0, mode1, mode2, in_side, out_side;

  assign mode0    = (group_a_mode == 2'b00);
  assign mode1    = (group_a_mode == 2'b01);
  assign mode2    = group_a_mode[1];
  assign in_side  = (mode1 & port_a_dir_in) | mode2;
  assign out_side = (mode1 & ~port_a_dir_in) | mode2;

  // Pin data shares the strobe's synchronizer depth so the latched byte
  // is the one present when the strobe fell.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      stb_sync <= '1;
      ack_sync <= '1;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) pin_sync[i] <= '0;
      stb_d  <= 1'b1;
      ack_d  <= 1'b1;
      read_d <= 1'b0;
    end else begin
      stb_sync[0] <= pa.stb_n;
      ack_sync[0] <= pa.ack_n;
      pin_sync[0] <= pa.port_a_pin_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stb_sync[i] <= stb_sync[i-1];
        ack_sync[i] <= ack_sync[i-1];
        pin_sync[i] <= pin_sync[i-1];
      end
      stb_d  <= stb_s;
      ack_d  <= ack_s;
      read_d <= pa.read_port_a;
    end
  end

  assign stb_s     = stb_sync[SYNC_STAGES-1];
  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign pin_s     = pin_sync[SYNC_STAGES-1];
  assign stb_fall  = stb_d & ~stb_s;
  assign stb_rise  = ~stb_d & stb_s;
  assign ack_fall  = ack_d & ~ack_s;
  assign ack_rise  = ~ack_d & ack_s;
  assign read_rise = pa.read_port_a & ~read_d;
  assign read_fall = ~pa.read_port_a & read_d;

  always_comb begin
    in_next       = in_state;
    out_next      = out_state;
    intr_in_next  = intr_in;
    intr_out_next = intr_out;
    load_latch    = 1'b0;
    intr_next     = (in_side & intr_in & inte2) | (out_side & intr_out & inte1);
    if (mode_write) begin
      in_next       = IN_EMPTY;
      out_next      = OUT_EMPTY;
      intr_in_next  = 1'b0;
      intr_out_next = 1'b0;
      intr_next     = 1'b0;
    end else begin
      if (!in_side) begin
        in_next      = IN_EMPTY;
        intr_in_next = 1'b0;
      end else begin
        // A new strobe outranks a read completing in the same cycle.
        if (stb_fall) begin
          in_next    = IN_FULL;
          load_latch = 1'b1;
        end else if (read_fall) begin
          in_next = IN_EMPTY;
        end
        if (read_rise) intr_in_next = 1'b0;
        else if (stb_rise && in_state == IN_FULL) intr_in_next = 1'b1;
      end
      if (!out_side) begin
        out_next      = OUT_EMPTY;
        intr_out_next = 1'b0;
      end else begin
        // A write outranks an acknowledge landing in the same cycle.
        if (pa.write_port_a) begin
          out_next      = OUT_FULL;
          intr_out_next = 1'b0;
        end else if (ack_fall) begin
          out_next = OUT_EMPTY;
        end else if (ack_rise && out_state == OUT_EMPTY) begin
          intr_out_next = 1'b1;
        end
      end
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      in_state  <= IN_EMPTY;
      out_state <= OUT_EMPTY;
      intr_in   <= 1'b0;
      intr_out  <= 1'b0;
      intr_q    <= 1'b0;
      in_latch  <= '0;
      out_data  <= '0;
      armed     <= 1'b0;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
      intr_in   <= intr_in_next;
      intr_out  <= intr_out_next;
      intr_q    <= intr_next;
      if (mode_write) begin
        in_latch <= '0;
        out_data <= '0;
        armed    <= 1'b0;
      end else begin
        if (load_latch) in_latch <= pin_s;
        if (pa.write_port_a) out_data <= pa.internal_data_bus;
        armed <= 1'b1;
      end
    end
  end

  // The driver stays off for the cycle after reset/mode-set so a freshly
  // configured port never drives stale data.
  assign pa.port_a_out_enable = armed & (mode2 ? ~ack_s : ~port_a_dir_in);
  assign pa.obf_n             = (out_state != OUT_FULL);
  assign pa.ibf               = (in_state == IN_FULL);
  assign pa.intr              = intr_q;
  assign pa.port_a_out_data   = out_data;
  assign pa.port_a_read_data  = mode0                   ? pin_s    :
                                (mode1 & ~port_a_dir_in) ? out_data : in_latch;

endmodule

// File: doc/kf8255_port_a_handshake.md
Name: kf8255_port_a_handshake

Overview:
- Handshake sequencer for 8255 Group A, port A, in Modes 1 and 2.
- Sits between the control logic's port-A read/write request flags and the port-A/port-C pins.
- Latches strobed input data and holds output data.
- Drives the Group A handshake lines: OBF_n (PC7), IBF (PC5), INTR (PC3).
- In Mode 0 it is transparent and every handshake output sits at its inactive level.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the pin synchronizer on stb_n, ack_n and port_a_pin_in. Minimum 1.

Ports:
- clock  input  1  system clock; all state updates on negedge clock.
- reset  input  1  asynchronous, active-high reset.
- group_a_mode  input  2  00 = Mode 0, 01 = Mode 1, 1x = Mode 2.
- port_a_dir_in  input  1  Modes 0/1 direction: 1 = input, 0 = output. Ignored in Mode 2.
- mode_write  input  1  one-cycle pulse when a mode-set control word is written.
- inte1  input  1  output-side interrupt enable (PC6 bit set/reset).
- inte2  input  1  input-side interrupt enable (PC4 bit set/reset).
- internal_data_bus  input  8  CPU write data.
- write_port_a  input  1  one-cycle pulse at the end of a CPU write to port A.
- read_port_a  input  1  level, high while a CPU read of port A is active.
- port_a_pin_in  input  8  port A pins, asynchronous.
- stb_n  input  1  PC4 strobe, asynchronous, active low.
- ack_n  input  1  PC6 acknowledge, asynchronous, active low.
- port_a_read_data  output  8  data returned to the CPU on a port A read.
- port_a_out_data  output  8  output latch.
- port_a_out_enable  output  1  port A pin driver enable.
- obf_n  output  1  output buffer full, active low.
- ibf  output  1  input buffer full.
- intr  output  1  Group A interrupt request.

Behaviour:
- Reset and mode_write (mode_write is synchronous, same effect as reset):
  - obf_n = 1, ibf = 0, intr = 0, both internal interrupt flags = 0.
  - input latch = 0x00, port_a_out_data = 0x00, port_a_out_enable = 0.
  - mode_write has priority over every other event in its cycle.
  - An asserted reset mid-handshake abandons the handshake immediately.
- Synchronizer and edge detection:
  - stb_n, ack_n and port_a_pin_in each pass through SYNC_STAGES flops; pin data shares the same delay as stb_n.
  - One further flop per control line gives falling/rising edge pulses.
  - Edge detection latency: SYNC_STAGES+1 clocks from the pin change.
- read_port_a:
  - Rise and fall of read_port_a are edge-detected with one flop.
- Input side (Mode 1 with port_a_dir_in = 1, or Mode 2), states IN_EMPTY and IN_FULL:
  - stb falling edge: input latch <= synchronized pin data, ibf <= 1 next cycle (IN_FULL).
  - stb falling edge while already IN_FULL: latch overwritten (overrun), ibf stays 1.
  - stb rising edge while IN_FULL: intr_in flag <= 1.
  - read_port_a rising edge: intr_in flag <= 0.
  - read_port_a falling edge: ibf <= 0 (IN_EMPTY).
  - stb falling edge in the same cycle as read falling edge: the stb event wins, ibf stays 1.
- Output side (Mode 1 with port_a_dir_in = 0, or Mode 2), states OUT_EMPTY and OUT_FULL:
  - write_port_a: port_a_out_data <= internal_data_bus, obf_n <= 0 (OUT_FULL), intr_out flag <= 0.
  - ack falling edge: obf_n <= 1 (OUT_EMPTY).
  - ack rising edge with obf_n = 1: intr_out flag <= 1.
  - write_port_a in the same cycle as ack falling edge: the write wins, obf_n = 0 with the new data.
- intr (registered):
  - Mode 1 input: intr_in & inte2.
  - Mode 1 output: intr_out & inte1.
  - Mode 2: (intr_in & inte2) | (intr_out & inte1).
  - Mode 0: 0.
  - A change of inte1 or inte2 takes effect on the next clock.
- port_a_out_enable:
  - Mode 0: ~port_a_dir_in.
  - Mode 1: ~port_a_dir_in.
  - Mode 2: 1 only while synchronized ack_n = 0.
- port_a_read_data:
  - Mode 0: synchronized pins.
  - Mode 1 input and Mode 2: input latch.
  - Mode 1 output: port_a_out_data.
- Mode 0 holds the handshake state machines in their empty states; writes still load port_a_out_data.

Test Plan:
- Reset check: assert reset mid-clock with obf_n = 0 and ibf = 1 -> immediately obf_n = 1, ibf = 0, intr = 0, port_a_out_enable = 0, port_a_out_data = 0x00.
- Mode 1 input, inte2 = 1, pins = 0x5A:
  - pulse stb_n low for 4 clocks -> ibf = 1 within SYNC_STAGES+2 clocks and port_a_read_data = 0x5A.
  - stb_n high -> intr = 1.
  - assert read_port_a -> intr = 0; release it -> ibf = 0.
- Mode 1 output, inte1 = 1:
  - write_port_a with bus = 0xC3 -> port_a_out_data = 0xC3, obf_n = 0 the next cycle, port_a_out_enable = 1.
  - ack_n low -> obf_n = 1; ack_n high -> intr = 1.
  - next write_port_a -> intr = 0.
- Mode 2 bidirectional:
  - write 0x81 -> port_a_out_enable = 0 until ack_n is low, then 1.
  - concurrent stb_n latches pins 0x7E -> ibf = 1.
  - intr = 1 when either flag is set with its INTE.
- Collisions:
  - write_port_a in the same cycle as the ack falling edge -> obf_n stays 0 with the new data.
  - stb falling edge in the same cycle as the read falling edge -> ibf stays 1.
  - stb falling edge while ibf = 1 with pins = 0x11 -> latch = 0x11, ibf stays 1.
- mode_write pulse while OUT_FULL and IN_FULL -> obf_n = 1, ibf = 0, intr = 0, latches 0x00 the next cycle.
